// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the parametrised raster timing generator.
// The defaults describe 320x480 visible on a 400x525 raster.
package video_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 320;
    localparam int unsigned DEF_H_FRONT   = 8;
    localparam int unsigned DEF_H_SYNC    = 48;
    localparam int unsigned DEF_H_BACK    = 24;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CNT_W     = 10;
    localparam int unsigned DEF_HSYNC_POL = 0;
    localparam int unsigned DEF_VSYNC_POL = 0;
    localparam int unsigned DEF_LOOKAHEAD = 2;
    localparam int unsigned DEF_FRAME_W   = 8;

    function automatic int unsigned axis_total(input int unsigned vis, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return vis + front + sync + back;
    endfunction

    function automatic int unsigned sync_start(input int unsigned vis, input int unsigned front);
        return vis + front;
    endfunction

    // Counter range must cover the longer of the two axes.
    function automatic bit cnt_w_fits(input int unsigned cnt_w, input int unsigned h_total,
                                      input int unsigned v_total);
        logic [63:0] cap;
        cap = 64'(1'b1) << cnt_w;
        return (cap >= 64'(h_total)) && (cap >= 64'(v_total));
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Timing bundle between the generator and its consumers (line buffer, fetch, VGA stage).
interface video_timing_if
    import video_timing_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned FRAME_W = DEF_FRAME_W
);
    logic               pixel_ce;
    logic               hsync;
    logic               vsync;
    logic [CNT_W-1:0]   hcounter;
    logic [CNT_W-1:0]   vcounter;
    logic               visible;
    logic               writable;
    logic               line_start;
    logic               frame_start;
    logic [CNT_W-1:0]   pre_x;
    logic [CNT_W-1:0]   pre_y;
    logic               pre_visible;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  pixel_ce,
        output hsync, vsync, hcounter, vcounter, visible, writable,
               line_start, frame_start, pre_x, pre_y, pre_visible, frame_count
    );

    modport slave (
        output pixel_ce,
        input  hsync, vsync, hcounter, vcounter, visible, writable,
               line_start, frame_start, pre_x, pre_y, pre_visible, frame_count
    );
endinterface

// File: rtl/video_timing_gen_axis.sv
// One raster axis: enabled wrapping counter plus visible/sync decode.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned VIS   = DEF_H_VISIBLE,
    parameter int unsigned FRONT = DEF_H_FRONT,
    parameter int unsigned SYNC  = DEF_H_SYNC,
    parameter int unsigned BACK  = DEF_H_BACK,
    parameter int unsigned POL   = 0,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap_c,
    output logic             o_visible_c,
    output logic             o_sync_c
);
    localparam int unsigned TOTAL = axis_total(VIS, FRONT, SYNC, BACK);
    localparam int unsigned SS    = sync_start(VIS, FRONT);

    // Decode compares run one bit wider so a boundary equal to 2^CNT_W stays exact.
    localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   L_VIS    = (CNT_W+1)'(VIS);
    localparam logic [CNT_W:0]   L_SS     = (CNT_W+1)'(SS);
    localparam logic [CNT_W:0]   L_SE     = (CNT_W+1)'(SS + SYNC);
    localparam logic             L_POL    = (POL != 0);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_cnt_x;
    logic             w_in_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_wrap_c ? '0 : r_count + CNT_W'(1);
        end
    end

    assign w_cnt_x     = {1'b0, r_count};
    assign w_in_sync   = (w_cnt_x >= L_SS) && (w_cnt_x < L_SE);
    assign o_count     = r_count;
    assign o_wrap_c    = (r_count == L_LAST);
    assign o_visible_c = (w_cnt_x < L_VIS);
    assign o_sync_c    = (w_in_sync && !rst) ? L_POL : ~L_POL;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, syncs, qualifiers, strobes, prefetch and frame count.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned HSYNC_POL = DEF_HSYNC_POL,
    parameter int unsigned VSYNC_POL = DEF_VSYNC_POL,
    parameter int unsigned LOOKAHEAD = DEF_LOOKAHEAD,
    parameter int unsigned FRAME_W   = DEF_FRAME_W
) (
    input  logic          clk,
    input  logic          rst,
    video_timing_if.master bus
);
    localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (!cnt_w_fits(CNT_W, H_TOTAL, V_TOTAL)) begin : g_bad_cnt_w
        $error("video_timing_gen: CNT_W too narrow for the raster totals");
    end
    if (LOOKAHEAD >= H_TOTAL) begin : g_bad_lookahead
        $error("video_timing_gen: LOOKAHEAD must be below H_TOTAL");
    end

    localparam logic [CNT_W:0] L_H_TOTAL = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0] L_LA      = (CNT_W+1)'(LOOKAHEAD);
    localparam logic [CNT_W:0] L_H_VIS   = (CNT_W+1)'(H_VISIBLE);
    localparam logic [CNT_W:0] L_V_VIS   = (CNT_W+1)'(V_VISIBLE);

    logic [CNT_W-1:0]   w_hcount, w_vcount;
    logic               w_h_wrap, w_v_wrap, w_hvis, w_vvis, w_hsync, w_vsync;
    logic               w_line_start;
    logic [CNT_W:0]     w_sum;
    logic [CNT_W-1:0]   w_pre_x, w_pre_y;
    logic [FRAME_W-1:0] r_frame;

    timing_axis #(
        .VIS(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POL(HSYNC_POL), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .i_en(bus.pixel_ce),
        .o_count(w_hcount), .o_wrap_c(w_h_wrap), .o_visible_c(w_hvis), .o_sync_c(w_hsync)
    );

    // Vertical axis steps on the last enabled pixel of each line.
    timing_axis #(
        .VIS(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POL(VSYNC_POL), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(clk), .rst(rst), .i_en(bus.pixel_ce & w_h_wrap),
        .o_count(w_vcount), .o_wrap_c(w_v_wrap), .o_visible_c(w_vvis), .o_sync_c(w_vsync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame <= '0;
        end else if (bus.pixel_ce && w_h_wrap && w_v_wrap) begin
            r_frame <= r_frame + FRAME_W'(1);
        end
    end

    // Prefetch coordinate wraps into the next line (and frame) when it runs off the raster.
    always_comb begin
        w_sum   = {1'b0, w_hcount} + L_LA;
        w_pre_x = CNT_W'(w_sum);
        w_pre_y = w_vcount;
        if (w_sum >= L_H_TOTAL) begin
            w_pre_x = CNT_W'(w_sum - L_H_TOTAL);
            w_pre_y = w_v_wrap ? '0 : w_vcount + CNT_W'(1);
        end
    end

    assign w_line_start    = bus.pixel_ce && (w_hcount == '0) && !rst;

    assign bus.hsync       = w_hsync;
    assign bus.vsync       = w_vsync;
    assign bus.hcounter    = w_hcount;
    assign bus.vcounter    = w_vcount;
    assign bus.visible     = w_hvis && w_vvis && !rst;
    assign bus.writable    = w_vvis && !rst;
    assign bus.line_start  = w_line_start;
    assign bus.frame_start = w_line_start && (w_vcount == '0);
    assign bus.pre_x       = w_pre_x;
    assign bus.pre_y       = w_pre_y;
    assign bus.pre_visible = ({1'b0, w_pre_x} < L_H_VIS) && ({1'b0, w_pre_y} < L_V_VIS) && !rst;
    assign bus.frame_count = r_frame;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a tiny raster and the default raster, both checked every cycle
// against a position-count model of the raster.
module tb_video_timing_gen;

    typedef struct {
        int hs, vs, hc, vc, vis, wr, ls, fs, px, py, pv, fc;
    } obs_t;

    typedef struct {
        int hv, hf, hsw, hb, vv, vf, vsw, vb, hpol, vpol, la, fw;
    } geom_t;

    logic clk;
    logic rst_s, rst_d;
    int   n_tests, n_fail, cyc;
    int   p_s, p_d;
    geom_t gs, gd;

    video_timing_if #(.CNT_W(5), .FRAME_W(2)) vif_s ();
    video_timing_if #(.CNT_W(10), .FRAME_W(8)) vif_d ();

    video_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .CNT_W(5), .HSYNC_POL(1), .VSYNC_POL(1), .LOOKAHEAD(3), .FRAME_W(2)
    ) u_small (
        .clk(clk), .rst(rst_s), .bus(vif_s)
    );

    video_timing_gen u_dflt (
        .clk(clk), .rst(rst_d), .bus(vif_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs from the number of enabled advances p since the last reset.
    function automatic obs_t model(geom_t g, int p, bit rs, bit ce);
        obs_t e;
        int ht, vt, line, s;
        bit hvis, vvis, hon, von;
        ht   = g.hv + g.hf + g.hsw + g.hb;
        vt   = g.vv + g.vf + g.vsw + g.vb;
        e.hc = p % ht;
        line = p / ht;
        e.vc = line % vt;
        e.fc = (line / vt) % (1 << g.fw);
        s    = e.hc + g.la;
        if (s >= ht) begin
            e.px = s - ht;
            e.py = (e.vc == vt - 1) ? 0 : e.vc + 1;
        end else begin
            e.px = s;
            e.py = e.vc;
        end
        hvis = e.hc < g.hv;
        vvis = e.vc < g.vv;
        hon  = (e.hc >= g.hv + g.hf) && (e.hc < g.hv + g.hf + g.hsw);
        von  = (e.vc >= g.vv + g.vf) && (e.vc < g.vv + g.vf + g.vsw);
        e.hs  = (hon && !rs) ? g.hpol : 1 - g.hpol;
        e.vs  = (von && !rs) ? g.vpol : 1 - g.vpol;
        e.vis = (hvis && vvis && !rs) ? 1 : 0;
        e.wr  = (vvis && !rs) ? 1 : 0;
        e.ls  = (ce && e.hc == 0 && !rs) ? 1 : 0;
        e.fs  = (e.ls == 1 && e.vc == 0) ? 1 : 0;
        e.pv  = (e.px < g.hv && e.py < g.vv && !rs) ? 1 : 0;
        return e;
    endfunction

    function automatic obs_t obs_small();
        obs_t o;
        o.hs = int'(vif_s.hsync);       o.vs = int'(vif_s.vsync);
        o.hc = int'(vif_s.hcounter);    o.vc = int'(vif_s.vcounter);
        o.vis = int'(vif_s.visible);    o.wr = int'(vif_s.writable);
        o.ls = int'(vif_s.line_start);  o.fs = int'(vif_s.frame_start);
        o.px = int'(vif_s.pre_x);       o.py = int'(vif_s.pre_y);
        o.pv = int'(vif_s.pre_visible); o.fc = int'(vif_s.frame_count);
        return o;
    endfunction

    function automatic obs_t obs_dflt();
        obs_t o;
        o.hs = int'(vif_d.hsync);       o.vs = int'(vif_d.vsync);
        o.hc = int'(vif_d.hcounter);    o.vc = int'(vif_d.vcounter);
        o.vis = int'(vif_d.visible);    o.wr = int'(vif_d.writable);
        o.ls = int'(vif_d.line_start);  o.fs = int'(vif_d.frame_start);
        o.px = int'(vif_d.pre_x);       o.py = int'(vif_d.pre_y);
        o.pv = int'(vif_d.pre_visible); o.fc = int'(vif_d.frame_count);
        return o;
    endfunction

    task automatic cmp(string inst, string tag, int o, int e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s.%s cyc=%0d observed=%0d expected=%0d", inst, tag, cyc, o, e);
        end
    endtask

    task automatic check_all(string inst, obs_t o, obs_t e);
        cmp(inst, "hsync", o.hs, e.hs);
        cmp(inst, "vsync", o.vs, e.vs);
        cmp(inst, "hcounter", o.hc, e.hc);
        cmp(inst, "vcounter", o.vc, e.vc);
        cmp(inst, "visible", o.vis, e.vis);
        cmp(inst, "writable", o.wr, e.wr);
        cmp(inst, "line_start", o.ls, e.ls);
        cmp(inst, "frame_start", o.fs, e.fs);
        cmp(inst, "pre_x", o.px, e.px);
        cmp(inst, "pre_y", o.py, e.py);
        cmp(inst, "pre_visible", o.pv, e.pv);
        cmp(inst, "frame_count", o.fc, e.fc);
    endtask

    // Drive one clock of inputs, check both instances mid-cycle, then advance the models.
    task automatic step(bit rs, bit cs, bit rd, bit cd);
        rst_s = rs; vif_s.pixel_ce = cs;
        rst_d = rd; vif_d.pixel_ce = cd;
        @(negedge clk);
        check_all("small", obs_small(), model(gs, p_s, rs, cs));
        check_all("dflt", obs_dflt(), model(gd, p_d, rd, cd));
        @(posedge clk);
        if (rs) p_s = 0; else if (cs) p_s++;
        if (rd) p_d = 0; else if (cd) p_d++;
        cyc++;
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; p_s = 0; p_d = 0;
        gs = '{hv:16, hf:2, hsw:3, hb:3, vv:6, vf:1, vsw:2, vb:2, hpol:1, vpol:1, la:3, fw:2};
        gd = '{hv:320, hf:8, hsw:48, hb:24, vv:480, vf:10, vsw:2, vb:33, hpol:0, vpol:0, la:2, fw:8};
        rst_s = 1'b1; rst_d = 1'b1;
        vif_s.pixel_ce = 1'b0; vif_d.pixel_ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Held in reset, then free-running one pixel per clock.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

        // Small raster on every other clock; default raster runs on to column 200 of line 1.
        for (int i = 0; i < 300; i++) step(1'b0, (i % 2) == 0, 1'b0, 1'b1);

        // One-cycle reset mid-line on the default raster.
        step(1'b0, 1'b1, 1'b1, 1'b1);

        // Random pixel enables across several small-raster frames (frame counter wraps).
        for (int i = 0; i < 1500; i++)
            step(1'b0, $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 1) == 1);

        // Random enables with sporadic resets.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 127) == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 400x525 raster timing generator.
- Generates h/v counters, syncs, visible/writable qualifiers and frame/line strobes for any raster geometry.
- Adds a pixel clock-enable, programmable sync polarity, a look-ahead prefetch coordinate and a frame counter.
- Sits between the pixel clock domain and the GPU line-buffer/fetch pipeline; feeds the VGA output stage.

Parameters:
- H_VISIBLE, 320, visible pixels per line
- H_FRONT, 8, horizontal front porch (pixels)
- H_SYNC, 48, horizontal sync width (pixels)
- H_BACK, 24, horizontal back porch (pixels); H_TOTAL = sum of the four = 400
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = 525
- CNT_W, 10, counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL), elaboration error otherwise
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- LOOKAHEAD, 2, pixels of prefetch lead; range 0..H_TOTAL-1
- FRAME_W, 8, frame counter width

Ports:
- clk, input, 1, pixel-domain clock
- rst, input, 1, synchronous, active-high reset
- pixel_ce, input, 1, counters advance only on cycles with pixel_ce=1
- hsync, output, 1, horizontal sync at HSYNC_POL
- vsync, output, 1, vertical sync at VSYNC_POL
- hcounter, output, CNT_W, current pixel column (registered)
- vcounter, output, CNT_W, current line (registered)
- visible, output, 1, hvisible & vvisible
- writable, output, 1, equals vvisible (line-buffer fill window)
- line_start, output, 1, one-cycle strobe at the first enabled cycle of each line
- frame_start, output, 1, one-cycle strobe at the first enabled cycle of each frame
- pre_x, output, CNT_W, column LOOKAHEAD pixels ahead of hcounter
- pre_y, output, CNT_W, line owning pre_x
- pre_visible, output, 1, (pre_x, pre_y) lies in the visible area
- frame_count, output, FRAME_W, completed-frame count

Behaviour:
- Reset, while rst=1 at a clk edge:
  - hcounter=0, vcounter=0, frame_count=0 after the edge.
  - All combinational qualifiers are forced inactive while rst=1: visible=0, writable=0, pre_visible=0, line_start=0, frame_start=0.
  - hsync and vsync sit at their inactive levels (~HSYNC_POL, ~VSYNC_POL).
  - Reset asserted mid-line or mid-frame aborts immediately; no pending strobe is emitted.
- Counters:
  - On a clk edge with rst=0 and pixel_ce=1, hcounter advances: it wraps H_TOTAL-1 -> 0, otherwise increments.
  - vcounter advances only when hcounter==H_TOTAL-1: it wraps V_TOTAL-1 -> 0, otherwise increments.
  - frame_count increments (mod 2^FRAME_W) on the same edge where both counters wrap.
  - pixel_ce=0 holds all registers unchanged.
  - pixel_ce tied 1 gives the legacy one-pixel-per-clock behaviour.
- Decode, combinational from registered counters, gated by !rst:
  - hvisible = hcounter < H_VISIBLE.
  - hsync active for H_VISIBLE+H_FRONT <= hcounter < H_VISIBLE+H_FRONT+H_SYNC.
  - The vertical axis is decoded the same way.
  - Defaults reproduce hsync on 328..375 and vsync on lines 490..491.
- Strobes:
  - line_start = pixel_ce & (hcounter==0) & !rst.
  - frame_start = line_start & (vcounter==0).
  - Both strobes repeat on every enabled cycle at those coordinates only, so they are exactly one enabled pixel wide.
  - The first enabled cycle after reset release produces frame_start=1.
- Prefetch, combinational:
  - Let s = hcounter + LOOKAHEAD.
  - If s >= H_TOTAL: pre_x = s - H_TOTAL, and pre_y = (vcounter==V_TOTAL-1) ? 0 : vcounter+1.
  - Otherwise pre_x = s and pre_y = vcounter.
  - Compute s at CNT_W+1 bits so it cannot overflow.
  - pre_visible = (pre_x < H_VISIBLE) & (pre_y < V_VISIBLE) & !rst.
  - LOOKAHEAD=0 makes pre_* equal the current position.
- Latency:
  - Outputs reflect the counters registered at the last enabled edge.
  - Zero additional pipeline stages, so sync and visible align to the same pixel.

Decomposition:
- Package video_timing_pkg holds:
  - localparams for the 320x480-on-400x525 default mode
  - a constant function for the total and sync-start computation
  - an elaboration check on CNT_W
- Natural sub-module: timing_axis, instantiated twice (horizontal and vertical). It contains:
  - the counter with enable and wrap
  - visible and sync decode from VIS/FRONT/SYNC/BACK/POL
  - a wrap output; the horizontal instance's wrap, ANDed with pixel_ce, drives the vertical instance's enable.

Test Plan:
- Defaults, pixel_ce=1, release rst -> frame_start on the first cycle; hsync low exactly at hcounter 328..375; vsync low exactly for vcounter 490..491; 210000 cycles per frame; frame_count=1 after one frame.
- pixel_ce pulsed every 2nd cycle -> counters advance once per 2 clocks; line period is 800 clocks; line_start width is 1 clock.
- hcounter=398, vcounter=524, LOOKAHEAD=2 -> pre_x=0, pre_y=0, pre_visible=1; on the next edge hcounter=399, then 0/0, with frame_start asserted.
- Assert rst at hcounter=200, vcounter=100 for 1 cycle -> during rst visible=0 and hsync/vsync inactive; the next edge gives 0/0; frame_count=0.
- HSYNC_POL=1, VSYNC_POL=1, geometry 640/16/96/48 x 480/10/2/33 -> H_TOTAL=800; hsync high only at 656..751; visible low at hcounter 640.
- FRAME_W=2, run 5 frames -> frame_count sequence 1, 2, 3, 0, 1.
